// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_resp data-memory responder:
// FSM state encoding, access-size codes, bus widths and byte-lane helpers.
package dmem_pkg;

   localparam int ADR_WIDTH = 32;
   localparam int CPU_WIDTH = 64;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Byte-enable mask for an access of the given size starting at byte lane off.
   function automatic logic [7:0] mask_of(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] m;
      case (size)
         SIZE_B:  m = 8'h01;
         SIZE_H:  m = 8'h03;
         SIZE_W:  m = 8'h0F;
         SIZE_D:  m = 8'hFF;
         default: m = 8'h00;
      endcase
      return m << off;
   endfunction

   // True when the lane offset is not a multiple of the access size.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
      logic mis;
      case (size)
         SIZE_B:  mis = 1'b0;
         SIZE_H:  mis = off[0];
         SIZE_W:  mis = (off[1:0] != 2'd0);
         SIZE_D:  mis = (off != 3'd0);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // One step of the x^4+x^3+1 Galois LFSR (right-shifting form).
   function automatic logic [3:0] lfsr_next(input logic [3:0] l);
      return {1'b0, l[3:1]} ^ (l[0] ? 4'b1100 : 4'b0000);
   endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// uni_if: data-side request/response bus between the LSU master and a responder.
interface uni_if;
   import dmem_pkg::*;

   logic                 valid;
   logic                 reqtyp;
   logic [ADR_WIDTH-1:0] addr;
   logic [CPU_WIDTH-1:0] wdata;
   logic [1:0]           size;
   logic                 ready;
   logic [CPU_WIDTH-1:0] rdata;

   modport Master (
      output valid, reqtyp, addr, wdata, size,
      input  ready, rdata
   );

   modport Slave (
      input  valid, reqtyp, addr, wdata, size,
      output ready, rdata
   );
endinterface

// File: rtl/dmem_sram.sv
// dmem_sram: DEPTH x 64 synchronous memory with per-byte write enables and a
// registered read port. Contents are never reset.
module dmem_sram #(
   parameter int DEPTH = 4096,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [7:0]    i_be,
   input  logic [IW-1:0] i_waddr,
   input  logic [63:0]   i_wdata,
   input  logic          i_re,
   input  logic [IW-1:0] i_raddr,
   output logic [63:0]   o_rdata
);

   logic [63:0] r_mem [0:DEPTH-1];
   logic [63:0] r_q;

   // Byte-lane write: only enabled lanes of the addressed word change.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 8; b++) begin
            if (i_be[b]) begin
               r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   // Registered read: data appears the cycle after i_re.
   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_q <= r_mem[i_raddr];
      end else begin
         r_q <= r_q;
      end
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: uni_if data-memory responder backed by a 64-bit wide array.
// Accepts one request at a time, waits a number of cycles, then pulses ready
// with right-justified load data and misalign/out-of-bounds flags.
// Optional build macro DMEM_RAND_LAT_EN: per-request wait count comes from a
// 4-bit Galois LFSR instead of WAIT_CYC.
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int          DEPTH     = 4096,
   parameter int          WAIT_CYC  = 2,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   uni_if.Slave uniIf_S,
   output logic o_misalign,
   output logic o_oob
);

   localparam int          IW        = $clog2(DEPTH);
   localparam logic [32:0] WIN_BYTES = 33'(DEPTH) * 33'd8;

   state_e        r_state;
   logic [3:0]    r_cnt;
   logic          r_reqtyp;
   logic [1:0]    r_size;
   logic [2:0]    r_off;
   logic [IW-1:0] r_idx;
   logic [63:0]   r_wdata;
   logic          r_oob;
   logic          r_mis;
   logic          r_ready;
   logic          r_mis_p;
   logic          r_oob_p;

   logic [31:0]   w_rel;
   logic          w_oob;
   logic          w_mis;
   logic          w_accept;
   logic          w_rd_last;
   logic [3:0]    w_wait_init;
   logic          w_sram_re;
   logic [IW-1:0] w_sram_raddr;
   logic          w_sram_we;
   logic [7:0]    w_be;
   logic [63:0]   w_sram_wdata;
   logic [63:0]   w_sram_q;
   logic [63:0]   w_load_sh;
   logic [63:0]   w_load;

   // Decode of the request currently on the bus (used only at accept).
   assign w_rel    = uniIf_S.addr - BASE_ADDR;
   assign w_oob    = ({1'b0, w_rel} >= WIN_BYTES);
   assign w_mis    = is_misaligned(uniIf_S.size, uniIf_S.addr[2:0]);
   assign w_accept = (r_state == IDLE) && uniIf_S.valid;
   assign w_rd_last = (r_state == WAIT) && uniIf_S.valid && (r_cnt <= 4'd1);

`ifdef DMEM_RAND_LAT_EN
   logic [3:0] r_lfsr;

   // Random wait source: steps once per accepted request, never reaches zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr <= 4'b1001;
      end else if (w_accept) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end else begin
         r_lfsr <= r_lfsr;
      end
   end

   assign w_wait_init = r_lfsr;
`else
   assign w_wait_init = 4'(WAIT_CYC);
`endif

   // Request FSM: capture at accept, count wait states, one-cycle response.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_reqtyp <= 1'b0;
         r_size   <= 2'd0;
         r_off    <= 3'd0;
         r_idx    <= '0;
         r_wdata  <= 64'd0;
         r_oob    <= 1'b0;
         r_mis    <= 1'b0;
         r_ready  <= 1'b0;
         r_mis_p  <= 1'b0;
         r_oob_p  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ready <= 1'b0;
               r_mis_p <= 1'b0;
               r_oob_p <= 1'b0;
               if (uniIf_S.valid) begin
                  r_reqtyp <= uniIf_S.reqtyp;
                  r_size   <= uniIf_S.size;
                  r_off    <= uniIf_S.addr[2:0];
                  r_idx    <= w_rel[IW+2:3];
                  r_wdata  <= uniIf_S.wdata;
                  r_oob    <= w_oob;
                  r_mis    <= w_mis;
                  if (w_wait_init == 4'd0) begin
                     r_state <= RESP;
                     r_cnt   <= 4'd0;
                     r_ready <= 1'b1;
                     r_mis_p <= w_mis;
                     r_oob_p <= w_oob;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= w_wait_init;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            WAIT: begin
               if (!uniIf_S.valid) begin
                  // Master withdrew the request: abandon without response.
                  r_state <= IDLE;
                  r_cnt   <= 4'd0;
               end else if (r_cnt <= 4'd1) begin
                  r_state <= RESP;
                  r_cnt   <= 4'd0;
                  r_ready <= 1'b1;
                  r_mis_p <= r_mis;
                  r_oob_p <= r_oob;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               r_state <= IDLE;
               r_ready <= 1'b0;
               r_mis_p <= 1'b0;
               r_oob_p <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= 4'd0;
               r_ready <= 1'b0;
               r_mis_p <= 1'b0;
               r_oob_p <= 1'b0;
            end
         endcase
      end
   end

   // Array read: at accept uses the live address (zero-wait case), otherwise
   // the captured index on the last wait cycle, so data lands in RESP.
   assign w_sram_re    = w_accept || w_rd_last;
   assign w_sram_raddr = (r_state == IDLE) ? w_rel[IW+2:3] : r_idx;

   // Store commit happens at the clock edge that ends the RESP cycle.
   assign w_sram_we    = (r_state == RESP) && r_reqtyp && !r_oob && !r_mis;
   assign w_be         = mask_of(r_size, r_off);
   assign w_sram_wdata = r_wdata << {r_off, 3'b000};

   dmem_sram #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_sram (
      .i_clk   (i_clk),
      .i_we    (w_sram_we),
      .i_be    (w_be),
      .i_waddr (r_idx),
      .i_wdata (w_sram_wdata),
      .i_re    (w_sram_re),
      .i_raddr (w_sram_raddr),
      .o_rdata (w_sram_q)
   );

   // Right-justify the addressed lanes and clear bits above the access size.
   always_comb begin
      w_load_sh = w_sram_q >> {r_off, 3'b000};
      w_load    = 64'd0;
      case (r_size)
         SIZE_B:  w_load = {56'd0, w_load_sh[7:0]};
         SIZE_H:  w_load = {48'd0, w_load_sh[15:0]};
         SIZE_W:  w_load = {32'd0, w_load_sh[31:0]};
         SIZE_D:  w_load = w_load_sh;
         default: w_load = 64'd0;
      endcase
   end

   assign uniIf_S.ready = r_ready;
   assign uniIf_S.rdata = (r_ready && !r_reqtyp && !r_oob && !r_mis) ? w_load : 64'd0;
   assign o_misalign    = r_mis_p;
   assign o_oob         = r_oob_p;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios plus randomized
// traffic compared against a byte-addressed memory model.
module tb_dmem_resp;
   import dmem_pkg::*;

   localparam int          DEPTH    = 4096;
   localparam int          WAIT_CYC = 2;
   localparam logic [31:0] BASE     = 32'h8000_0000;

`ifdef DMEM_RAND_LAT_EN
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 16;
   localparam int DROP_AT = 1;
`else
   localparam int LAT_MIN = WAIT_CYC + 1;
   localparam int LAT_MAX = WAIT_CYC + 1;
   localparam int DROP_AT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        misalign;
   logic        oob;
   int          n_err = 0;
   int          n_chk = 0;
   logic [63:0] last_rd;
   logic [7:0]  mbytes [0:DEPTH*8-1];

   uni_if u_if();

   dmem_resp #(
      .DEPTH     (DEPTH),
      .WAIT_CYC  (WAIT_CYC),
      .BASE_ADDR (BASE)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .uniIf_S    (u_if),
      .o_misalign (misalign),
      .o_oob      (oob)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: memory as a flat byte array, accesses as byte loops.
   task automatic model(input logic st, input logic [31:0] a, input logic [63:0] wd,
                        input logic [1:0] sz, output logic [63:0] rd,
                        output logic mis, output logic oo);
      logic [31:0] rel;
      int          n;
      rel = a - BASE;
      n   = 1 << sz;
      oo  = (rel >= 32'(DEPTH * 8));
      mis = ((a % n) != 0);
      rd  = 64'd0;
      if (!oo && !mis) begin
         for (int i = 0; i < n; i++) begin
            if (st) mbytes[rel + i] = wd[8*i +: 8];
            else    rd[8*i +: 8]   = mbytes[rel + i];
         end
      end
   endtask

   task automatic txn(input string tag, input logic st, input logic [31:0] a,
                      input logic [63:0] wd, input logic [1:0] sz);
      logic [63:0] e_rd;
      logic        e_mis, e_oob, seen;
      int          lat;
      model(st, a, wd, sz, e_rd, e_mis, e_oob);
      @(negedge clk);
      u_if.valid  = 1'b1;
      u_if.reqtyp = st;
      u_if.addr   = a;
      u_if.wdata  = wd;
      u_if.size   = sz;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         seen = u_if.ready;
         if (!seen) begin
            // Bus contents after accept must not matter.
            u_if.addr  = $urandom;
            u_if.wdata = {$urandom, $urandom};
         end
      end
      check({tag, ":ready"}, 64'(seen), 64'd1);
      if (seen) begin
         check({tag, ":lat"}, 64'(lat >= LAT_MIN && lat <= LAT_MAX), 64'd1);
         if (!st) check({tag, ":rdata"}, u_if.rdata, e_rd);
         check({tag, ":mis"}, 64'(misalign), 64'(e_mis));
         check({tag, ":oob"}, 64'(oob), 64'(e_oob));
         last_rd = u_if.rdata;
      end
      u_if.valid = 1'b0;
      @(negedge clk);
      check({tag, ":pulse"}, 64'(u_if.ready), 64'd0);
   endtask

   initial begin
      logic        seen;
      int          r, k;
      logic [31:0] a;

      rst_n       = 1'b0;
      u_if.valid  = 1'b0;
      u_if.reqtyp = 1'b0;
      u_if.addr   = 32'd0;
      u_if.wdata  = 64'd0;
      u_if.size   = 2'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(u_if.ready), 64'd0);
      check("rst_rdata", u_if.rdata, 64'd0);
      check("rst_mis", 64'(misalign), 64'd0);
      check("rst_oob", 64'(oob), 64'd0);
      rst_n = 1'b1;

      // Give the low 128 bytes and word 0 known contents.
      for (int i = 0; i < 16; i++) txn("init", 1'b1, BASE + 32'(8 * i), {$urandom, $urandom}, SIZE_D);

      txn("tp_st_d", 1'b1, BASE, 64'h0123456789ABCDEF, SIZE_D);
      txn("tp_ld_d", 1'b0, BASE, 64'd0, SIZE_D);
      check("tp_dword", last_rd, 64'h0123456789ABCDEF);
      txn("tp_st_b", 1'b1, BASE + 32'd5, 64'h00000000000000AA, SIZE_B);
      txn("tp_ld_d2", 1'b0, BASE, 64'd0, SIZE_D);
      check("tp_merge", last_rd, 64'h0123AA6789ABCDEF);
      txn("tp_ld_b", 1'b0, BASE + 32'd5, 64'd0, SIZE_B);
      check("tp_byte", last_rd, 64'h00000000000000AA);
      txn("tp_misw", 1'b0, BASE + 32'd6, 64'd0, SIZE_W);
      txn("tp_mis_st", 1'b1, BASE + 32'd6, 64'hFFFF_FFFF_FFFF_FFFF, SIZE_W);
      txn("tp_ld_d3", 1'b0, BASE, 64'd0, SIZE_D);
      check("tp_mis_keep", last_rd, 64'h0123AA6789ABCDEF);
      txn("tp_oob_st", 1'b1, BASE + 32'(DEPTH * 8), 64'h1111_2222_3333_4444, SIZE_D);
      txn("tp_oob_ld", 1'b0, BASE - 32'd8, 64'd0, SIZE_D);
      txn("tp_ld_w0", 1'b0, BASE, 64'd0, SIZE_D);
      check("tp_oob_keep", last_rd, 64'h0123AA6789ABCDEF);

      // Master drops valid during WAIT: no response, no write.
      @(negedge clk);
      u_if.valid  = 1'b1;
      u_if.reqtyp = 1'b1;
      u_if.addr   = BASE + 32'd8;
      u_if.wdata  = 64'hDEAD_BEEF_CAFE_F00D;
      u_if.size   = SIZE_D;
      seen = 1'b0;
      repeat (DROP_AT) begin
         @(negedge clk);
         seen = seen | u_if.ready;
      end
      u_if.valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | u_if.ready;
      end
      check("cancel_noready", 64'(seen), 64'd0);
      txn("cancel_ld", 1'b0, BASE + 32'd8, 64'd0, SIZE_D);

      // Asynchronous reset while waiting.
      @(negedge clk);
      u_if.valid  = 1'b1;
      u_if.reqtyp = 1'b1;
      u_if.addr   = BASE + 32'd16;
      u_if.wdata  = 64'h0F0F_0F0F_0F0F_0F0F;
      u_if.size   = SIZE_D;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_wait_ready", 64'(u_if.ready), 64'd0);
      check("arst_wait_mis", 64'(misalign), 64'd0);
      check("arst_wait_oob", 64'(oob), 64'd0);
      u_if.valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset during the response cycle of a store.
      @(negedge clk);
      u_if.valid  = 1'b1;
      u_if.reqtyp = 1'b1;
      u_if.addr   = BASE + 32'd24;
      u_if.wdata  = 64'h5555_AAAA_5555_AAAA;
      u_if.size   = SIZE_D;
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         seen = u_if.ready;
      end
      check("arst_rsp_seen", 64'(seen), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_rsp_ready", 64'(u_if.ready), 64'd0);
      u_if.valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      txn("arst_ld16", 1'b0, BASE + 32'd16, 64'd0, SIZE_D);
      txn("arst_ld24", 1'b0, BASE + 32'd24, 64'd0, SIZE_D);

      // Randomized traffic against the model.
      for (int i = 0; i < 120; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 8)       a = BASE + 32'(DEPTH * 8) + 32'($urandom_range(0, 63));
         else if (r < 12) a = BASE - 32'd1 - 32'($urandom_range(0, 63));
         else             a = BASE + 32'($urandom_range(0, 127));
         txn("rnd", 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Responder end of the uni_if data-side protocol. The LSU master issues load, store and fence.i requests; this block answers them.
- Backs requests with an internal 64-bit-wide synchronous memory array.
- Inserts a configurable number of wait states and returns lane-aligned, right-justified read data.
- Used as the data-memory responder in simulation/FPGA builds without a real dcache, and as a reference model for dcache verification.

Parameters:
- DEPTH, 4096, number of 64-bit words in the array (power of 2).
- WAIT_CYC, 2, wait states between request accept and the ready pulse (0..15).
- BASE_ADDR, 32'h80000000, first byte address mapped to word 0.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- uniIf_S  modport Slave  -  uni_if slave side, with these signals:
  - valid  in  1  request valid
  - reqtyp  in  1  1 = store, 0 = load/fence.i
  - addr  in  ADR_WIDTH  byte address
  - wdata  in  CPU_WIDTH  store data, right-justified
  - size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
  - ready  out  1  completion pulse
  - rdata  out  CPU_WIDTH  load data, right-justified
- o_misalign  out  1  one-cycle pulse, coincident with ready, when the request was misaligned
- o_oob  out  1  one-cycle pulse, coincident with ready, when the address is outside the mapped window

Behaviour:
- Reset is asynchronous, active low, on i_rst_n; clock is i_clk.
  - Reset values: ready = 0, rdata = 0, o_misalign = 0, o_oob = 0, FSM = IDLE, wait counter = 0.
  - Array contents are not reset.
  - Reset mid-transaction abandons the transaction; no write is committed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when valid = 1, latch reqtyp/addr/wdata/size into request registers. Go to WAIT with counter = WAIT_CYC, or straight to RESP if WAIT_CYC = 0.
  - WAIT: counter decrements each cycle; at 0 go to RESP. The array read for loads is issued on the last WAIT cycle (or in the IDLE accept cycle if WAIT_CYC = 0) so data is ready in RESP.
  - RESP: ready = 1 for exactly one cycle, with rdata and the flag pulses. Store write commits at this clock edge. Next state is IDLE.
- Minimum latency is valid-rise to ready = WAIT_CYC + 1 cycles. Back-to-back requests take one IDLE cycle between ready and the next accept.
- Valid dropped by the master (flush/exception/interrupt) while in WAIT:
  - Transaction is cancelled, return to IDLE next cycle.
  - No ready pulse, no write.
  - Valid dropping in the RESP cycle has no effect; the transaction completes.
- Index and offset: word index = (addr - BASE_ADDR)[log2(DEPTH)+2:3]; byte offset = addr[2:0].
- Out-of-bounds: (addr - BASE_ADDR) ≥ DEPTH*8 gives o_oob = 1, rdata = 0, no write, ready still asserted.
- Misaligned: offset not a multiple of (1 << size) gives o_misalign = 1, rdata = 0, no write, ready still asserted.
- Stores: byte-enable mask is ((1 << (1 << size)) - 1) << offset, and the data is wdata << (8*offset). Lanes outside the mask are unchanged.
- Loads: rdata = word >> (8*offset), with bits above the access size zeroed. The master performs sign/zero extension.
- fence.i arrives as a load (reqtyp = 0). It is served as an ordinary load and is harmless; no internal buffers exist to flush.
- Request registers are captured only at accept. Changes on addr/wdata while in WAIT are ignored.

Optional Feature:
- Macro: DMEM_RAND_LAT_EN.
- When defined:
  - The wait count per request is taken from a 4-bit Galois LFSR (polynomial x^4+x^3+1, reset seed 4'b1001).
  - The LFSR advances once per accepted request; WAIT_CYC is ignored.
  - This stresses the master's handshake.
- When undefined: the fixed WAIT_CYC is used and no LFSR is synthesized.

Decomposition:
- Shared package dmem_pkg holds:
  - the FSM state enum (IDLE/WAIT/RESP);
  - SIZE_B/SIZE_H/SIZE_W/SIZE_D constants;
  - a function mask_of(size, off) returning the 8-bit byte-enable mask.
- One sub-module, dmem_sram: synchronous byte-enable write, registered read, DEPTH x 64.

Test Plan:
- Store dword 64'h0123456789ABCDEF at 0x80000000 (size 3), then load size 3 -> rdata = 64'h0123456789ABCDEF; ready arrives WAIT_CYC+1 cycles after valid.
- Store byte 8'hAA at 0x80000005, then load dword at 0x80000000 -> rdata = 64'h0123AA6789ABCDEF; load byte at 0x80000005 -> rdata = 64'h00000000000000AA.
- Load word at 0x80000006 -> ready = 1, o_misalign = 1, rdata = 0, array unchanged.
- Store to BASE_ADDR + DEPTH*8 -> o_oob = 1 with ready, no write; a subsequent load of word 0 is unchanged.
- Assert valid for a store, drop it in the second WAIT cycle -> no ready pulse, location unchanged, FSM back in IDLE; next request served normally.
- Assert i_rst_n = 0 asynchronously mid-WAIT -> ready/flags = 0 immediately, FSM = IDLE; with DMEM_RAND_LAT_EN, 100 random requests all complete with latencies in 1..16.
